// File: rtl/dm_bus_arbiter_if.sv
// Master-side bus of the data-memory arbiter: one request/response channel per master.
// Latency: none, wiring only; the arbiter answers a request two cycles after it is seen in IDLE.
// Backpressure: req is held until the one-cycle ack pulse; no other stall signal exists.
interface dm_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    // Requesting engine (CPU M-stage or DMA/loader) drives the request side.
    modport master (
        output req, we, addr, byteen, wdata,
        input  ack, err, rdata
    );

    // Arbiter samples the request and drives the completion side.
    modport slave (
        input  req, we, addr, byteen, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter for the DM/timer/interrupt-generator bus, IDLE/ISSUE/RESP sequencing with address decode.
// Latency: request seen in IDLE -> slave strobe next cycle -> ack the cycle after; 3 cycles per access.
// Backpressure: masters hold req until ack; a tie goes round-robin, or always to M0 with ARB_CPU_PRIORITY_EN defined.
module dm_bus_arbiter #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] IG_BASE  = 32'h0000_7F20
) (
    input  logic               clk,
    input  logic               reset_n,
    dm_bus_arbiter_if.slave    m0,
    dm_bus_arbiter_if.slave    m1,
    output logic               dm_en,
    output logic               dm_we,
    output logic [31:0]        dm_addr,
    output logic [3:0]         dm_byteen,
    output logic [31:0]        dm_wdata,
    input  logic [31:0]        dm_rdata,
    output logic [2:0]         dev_we,
    output logic [31:0]        dev_addr,
    output logic [31:0]        dev_wdata,
    input  logic [31:0]        tc0_rdata,
    input  logic [31:0]        tc1_rdata,
    output logic               grant_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Window sizes in bytes: timers expose three words, the interrupt generator one.
    localparam logic [31:0] DM_SPAN  = DM_LIMIT - DM_BASE;
    localparam logic [31:0] TC_BYTES = 32'd12;
    localparam logic [31:0] IG_BYTES = 32'd4;
    // Timer COUNT register offset; it is read-only.
    localparam logic [31:0] TC_COUNT_OFF = 32'h0000_0008;

    state_t      state;
    logic        last_grant;
    logic        grant_id_q;

    // Transaction captured at grant time; everything downstream decodes from these.
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  byteen_q;
    logic [31:0] wdata_q;

    // Response registers, loaded in ISSUE and presented in RESP.
    logic        ack0_q;
    logic        ack1_q;
    logic        err_q;
    logic        rsel_dm_q;
    logic [31:0] resp_q;

    // Arbitration result for the current IDLE cycle.
    logic        pick_vld;
    logic        pick;

    // Address decode of the latched transaction.
    logic [31:0] dm_off;
    logic [31:0] tc0_off;
    logic [31:0] tc1_off;
    logic [31:0] ig_off;
    logic [31:0] tmr_off;
    logic        hit_dm;
    logic        hit_tc0;
    logic        hit_tc1;
    logic        hit_tmr;
    logic        hit_ig;
    logic        illegal;
    logic        in_issue;

    // Pick a master: a lone requester wins; a tie follows the configured policy.
    always_comb begin
        pick_vld = m0.req | m1.req;
        pick     = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
        // CPU port always wins a tie; last_grant is tracked but not consulted.
        pick = ~m0.req;
`else
        if (m0.req && m1.req) begin
            pick = ~last_grant;
        end else begin
            pick = ~m0.req;
        end
`endif
    end

    // Window hits use offset-from-base so a below-base address wraps to a large offset and misses.
    always_comb begin
        dm_off  = addr_q - DM_BASE;
        tc0_off = addr_q - TC0_BASE;
        tc1_off = addr_q - TC1_BASE;
        ig_off  = addr_q - IG_BASE;
        hit_dm  = (dm_off <= DM_SPAN);
        hit_tc0 = (tc0_off < TC_BYTES);
        hit_tc1 = (tc1_off < TC_BYTES);
        hit_ig  = (ig_off < IG_BYTES);
        hit_tmr = hit_tc0 | hit_tc1;
        tmr_off = hit_tc0 ? tc0_off : tc1_off;
    end

    // Any one of these conditions turns the access into an error response with no slave strobe.
    always_comb begin
        illegal = 1'b0;
        if (!(hit_dm || hit_tmr || hit_ig)) begin
            illegal = 1'b1;
        end
        if (addr_q[1:0] != 2'b00) begin
            illegal = 1'b1;
        end
        if (byteen_q == 4'h0) begin
            illegal = 1'b1;
        end
        if (hit_tmr && (byteen_q != 4'hF)) begin
            illegal = 1'b1;
        end
        if (hit_tmr && we_q && (tmr_off == TC_COUNT_OFF)) begin
            illegal = 1'b1;
        end
        if (hit_ig && !we_q) begin
            illegal = 1'b1;
        end
    end

    // Slave-side strobes exist only in ISSUE and only for legal accesses, so reset drops them at once.
    always_comb begin
        in_issue  = (state == ISSUE);
        dm_en     = in_issue & hit_dm & ~illegal;
        dm_we     = dm_en & we_q;
        dm_addr   = addr_q;
        dm_byteen = byteen_q;
        dm_wdata  = wdata_q;
        dev_we    = {3{in_issue & we_q & ~illegal}} & {hit_ig, hit_tc1, hit_tc0};
        dev_addr  = addr_q;
        dev_wdata = wdata_q;
    end

    // Sequencer: grant and latch in IDLE, strobe and capture in ISSUE, answer in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            byteen_q   <= '0;
            wdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            err_q      <= 1'b0;
            rsel_dm_q  <= 1'b0;
            resp_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    err_q     <= 1'b0;
                    rsel_dm_q <= 1'b0;
                    resp_q    <= '0;
                    if (pick_vld) begin
                        grant_id_q <= pick;
                        last_grant <= pick;
                        we_q       <= pick ? m1.we     : m0.we;
                        addr_q     <= pick ? m1.addr   : m0.addr;
                        byteen_q   <= pick ? m1.byteen : m0.byteen;
                        wdata_q    <= pick ? m1.wdata  : m0.wdata;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    err_q     <= illegal;
                    // DM read data only arrives in RESP, so it is steered there rather than captured.
                    rsel_dm_q <= hit_dm & ~we_q & ~illegal;
                    if (!illegal && !we_q && hit_tc0) begin
                        resp_q <= tc0_rdata;
                    end else if (!illegal && !we_q && hit_tc1) begin
                        resp_q <= tc1_rdata;
                    end else begin
                        resp_q <= '0;
                    end
                    ack0_q <= ~grant_id_q;
                    ack1_q <= grant_id_q;
                    state  <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion outputs: only the granted master ever sees a non-zero value.
    assign m0.ack   = ack0_q;
    assign m0.err   = ack0_q & err_q;
    assign m0.rdata = ack0_q ? (rsel_dm_q ? dm_rdata : resp_q) : 32'h0;
    assign m1.ack   = ack1_q;
    assign m1.err   = ack1_q & err_q;
    assign m1.rdata = ack1_q ? (rsel_dm_q ? dm_rdata : resp_q) : 32'h0;

    assign grant_id = grant_id_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Bench for dm_bus_arbiter: single-access vector table, tie arbitration and mid-transaction reset.
// Latency: expects the slave strobe one cycle and the ack two cycles after a request is seen in IDLE.
// Backpressure: requests are held until ack; completions are matched against an in-order expectation queue.
module tb_dm_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        dm_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_byteen;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic [2:0]  dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] tc0_rdata;
    logic [31:0] tc1_rdata;
    logic        grant_id;
    logic        busy;

    dm_bus_arbiter_if m0_if ();
    dm_bus_arbiter_if m1_if ();

    dm_bus_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .dm_en     (dm_en),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_byteen (dm_byteen),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dev_we    (dev_we),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .tc0_rdata (tc0_rdata),
        .tc1_rdata (tc1_rdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          mst;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] dmr;
        bit          e_dm_en;
        logic [2:0]  e_dev_we;
        bit          e_err;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        bit          mst;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    localparam int NVEC = 16;
    localparam logic [31:0] TC0_VAL = 32'h1111_2222;
    localparam logic [31:0] TC1_VAL = 32'h3333_4444;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit mst, bit we, logic [31:0] a, logic [3:0] be, logic [31:0] wd,
                                logic [31:0] dmr, bit den, logic [2:0] dw, bit e, logic [31:0] rd);
        vec_t v;
        v.mst = mst; v.we = we; v.addr = a; v.be = be; v.wdata = wd; v.dmr = dmr;
        v.e_dm_en = den; v.e_dev_we = dw; v.e_err = e; v.e_rdata = rd;
        return v;
    endfunction

    task automatic drive_req(input bit mst, input bit we, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        if (mst == 1'b0) begin
            m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = a; m0_if.byteen = be; m0_if.wdata = wd;
        end else begin
            m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = a; m1_if.byteen = be; m1_if.wdata = wd;
        end
    endtask

    task automatic drop_req(input bit mst);
        if (mst == 1'b0) m0_if.req = 1'b0;
        else             m1_if.req = 1'b0;
    endtask

    // Completion monitor: every ack must match the oldest expectation; the idle master stays quiet.
    always @(negedge clk) begin
        if (m0_if.ack === 1'b1 || m1_if.ack === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got m0_ack=%b m1_ack=%b expected none", m0_if.ack, m1_if.ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.mst == 1'b0) begin
                    check("ack_m0", {31'b0, m0_if.ack}, 32'd1);
                    check("err_m0", {31'b0, m0_if.err}, {31'b0, e.err});
                    check("rdata_m0", m0_if.rdata, e.rdata);
                    check("idle_m1_quiet", {m1_if.rdata[31:2], m1_if.err, m1_if.ack} | {30'b0, |m1_if.rdata[1:0], 1'b0}, 32'd0);
                end else begin
                    check("ack_m1", {31'b0, m1_if.ack}, 32'd1);
                    check("err_m1", {31'b0, m1_if.err}, {31'b0, e.err});
                    check("rdata_m1", m1_if.rdata, e.rdata);
                    check("idle_m0_quiet", {m0_if.rdata[31:2], m0_if.err, m0_if.ack} | {30'b0, |m0_if.rdata[1:0], 1'b0}, 32'd0);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        logic ack_seen;
        @(posedge clk); #1;
        dm_rdata = v.dmr;
        drive_req(v.mst, v.we, v.addr, v.be, v.wdata);
        sb.push_back('{v.mst, v.e_err, v.e_rdata});
        @(posedge clk); #1;
        check($sformatf("v%0d_busy_issue", idx), {31'b0, busy}, 32'd1);
        check($sformatf("v%0d_grant_id", idx), {31'b0, grant_id}, {31'b0, v.mst});
        check($sformatf("v%0d_dm_en", idx), {31'b0, dm_en}, {31'b0, v.e_dm_en});
        check($sformatf("v%0d_dm_we", idx), {31'b0, dm_we}, {31'b0, v.e_dm_en & v.we});
        check($sformatf("v%0d_dev_we", idx), {29'b0, dev_we}, {29'b0, v.e_dev_we});
        if (v.e_dm_en) begin
            check($sformatf("v%0d_dm_addr", idx), dm_addr, v.addr);
            check($sformatf("v%0d_dm_byteen", idx), {28'b0, dm_byteen}, {28'b0, v.be});
            if (v.we) check($sformatf("v%0d_dm_wdata", idx), dm_wdata, v.wdata);
        end
        if (v.e_dev_we != 3'b000) begin
            check($sformatf("v%0d_dev_wdata", idx), dev_wdata, v.wdata);
        end
        @(posedge clk); #1;
        ack_seen = v.mst ? m1_if.ack : m0_if.ack;
        check($sformatf("v%0d_ack_latency", idx), {31'b0, ack_seen}, 32'd1);
        drop_req(v.mst);
        @(posedge clk); #1;
        check($sformatf("v%0d_busy_done", idx), {31'b0, busy}, 32'd0);
    endtask

    // Hard stop in case anything above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_ids [3];
        int last_m0;
        int last_m1;

        //        mst we addr           be     wdata          dmr            den dev_we err rdata
        vecs[0]  = mk(0, 0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1, 3'b000, 0, 32'hDEAD_BEEF);
        vecs[1]  = mk(1, 1, 32'h0000_7F04, 4'h3, 32'h0000_00AA, 32'h0,         0, 3'b000, 1, 32'h0);
        vecs[2]  = mk(1, 1, 32'h0000_7F08, 4'hF, 32'h0000_00BB, 32'h0,         0, 3'b000, 1, 32'h0);
        vecs[3]  = mk(1, 1, 32'h0000_7F14, 4'hF, 32'h1234_5678, 32'h0,         0, 3'b010, 0, 32'h0);
        vecs[4]  = mk(0, 0, 32'h0000_4000, 4'hF, 32'h0,         32'h5555_AAAA, 0, 3'b000, 1, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0000_7F04, 4'hF, 32'h0,         32'h0,         0, 3'b000, 0, TC0_VAL);
        vecs[6]  = mk(1, 0, 32'h0000_7F18, 4'hF, 32'h0,         32'h0,         0, 3'b000, 0, TC1_VAL);
        vecs[7]  = mk(0, 0, 32'h0000_7F20, 4'hF, 32'h0,         32'h0,         0, 3'b000, 1, 32'h0);
        vecs[8]  = mk(0, 1, 32'h0000_7F20, 4'hF, 32'h0000_0001, 32'h0,         0, 3'b100, 0, 32'h0);
        vecs[9]  = mk(0, 1, 32'h0000_2FFC, 4'hC, 32'hA5A5_0000, 32'h0,         1, 3'b000, 0, 32'h0);
        vecs[10] = mk(1, 0, 32'h0000_3000, 4'hF, 32'h0,         32'h7777_7777, 0, 3'b000, 1, 32'h0);
        vecs[11] = mk(0, 1, 32'h0000_0002, 4'hF, 32'h0,         32'h0,         0, 3'b000, 1, 32'h0);
        vecs[12] = mk(0, 0, 32'h0000_0000, 4'h0, 32'h0,         32'h9999_0000, 0, 3'b000, 1, 32'h0);
        vecs[13] = mk(1, 1, 32'h0000_7F00, 4'hF, 32'h0000_0C0D, 32'h0,         0, 3'b001, 0, 32'h0);
        vecs[14] = mk(0, 0, 32'h0000_7F0C, 4'hF, 32'h0,         32'h0,         0, 3'b000, 1, 32'h0);
        vecs[15] = mk(1, 0, 32'h0000_2FFC, 4'hF, 32'h0,         32'hCAFE_F00D, 1, 3'b000, 0, 32'hCAFE_F00D);

        reset_n   = 1'b0;
        dm_rdata  = 32'h0;
        tc0_rdata = TC0_VAL;
        tc1_rdata = TC1_VAL;
        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = 32'h0; m0_if.byteen = 4'h0; m0_if.wdata = 32'h0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h0; m1_if.byteen = 4'h0; m1_if.wdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_grant_id", {31'b0, grant_id}, 32'd0);
        check("rst_acks", {30'b0, m1_if.ack, m0_if.ack}, 32'd0);
        check("rst_strobes", {28'b0, dev_we, dm_en}, 32'd0);
        check("rst_rdata", m0_if.rdata | m1_if.rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset during ISSUE of an M0 store: strobe falls without a clock and no ack follows.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'h0000_0040, 4'hF, 32'h0BAD_0BAD);
        @(posedge clk); #1;
        check("rstmid_dm_en_before", {31'b0, dm_en}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_dm_en_after", {31'b0, dm_en}, 32'd0);
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        drop_req(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_ack", {30'b0, m1_if.ack, m0_if.ack}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Tie from the first IDLE after reset; M0 keeps re-requesting after its first ack.
`ifdef ARB_CPU_PRIORITY_EN
        exp_ids = '{1'b0, 1'b0, 1'b1};
        last_m0 = 1;
        last_m1 = 2;
`else
        exp_ids = '{1'b0, 1'b1, 1'b0};
        last_m0 = 2;
        last_m1 = 1;
`endif
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_AAAA);
        drive_req(1'b1, 1'b1, 32'h0000_0024, 4'hF, 32'h0000_BBBB);
        for (int g = 0; g < 3; g++) begin
            sb.push_back('{exp_ids[g], 1'b0, 32'h0});
        end
        for (int g = 0; g < 3; g++) begin
            @(posedge clk); #1;
            check($sformatf("tie%0d_grant_id", g), {31'b0, grant_id}, {31'b0, exp_ids[g]});
            check($sformatf("tie%0d_dm_addr", g), dm_addr, exp_ids[g] ? 32'h0000_0024 : 32'h0000_0020);
            check($sformatf("tie%0d_dm_we", g), {31'b0, dm_we}, 32'd1);
            @(posedge clk); #1;
            if (g == last_m0) drop_req(1'b0);
            if (g == last_m1) drop_req(1'b1);
            @(posedge clk); #1;
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        check("final_busy", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
